// File: rtl/line_memory_responder.sv
// Fixed-latency line memory that answers cache line reads and writes.
// Each request is latched once and committed LATENCY edges after BUSY is entered.
module line_memory_responder #(
  parameter int LATENCY    = 4,
  parameter int INDEX_BITS = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         mem_read_en,
  input  logic         mem_write_en,
  input  logic [29:0]  mem_addr,
  input  logic [127:0] mem_write_data,
  output logic [127:0] mem_read_data,
  output logic         mem_busywait
);

  localparam int DEPTH = 1 << INDEX_BITS;
  localparam logic [3:0] COUNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state, state_nxt;
  logic [3:0]              count;
  logic                    req_write;
  logic [INDEX_BITS-1:0]   req_index;
  logic [127:0]            req_data;
  logic                    start, commit;
  logic [127:0]            lines [DEPTH];

  // The alias bits above the index are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[29:INDEX_BITS];

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt    = state;
    mem_busywait = 1'b0;
    start        = 1'b0;
    commit       = 1'b0;
    unique case (state)
      IDLE: begin
        mem_busywait = mem_read_en | mem_write_en;
        if (mem_read_en | mem_write_en) begin
          start     = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        mem_busywait = 1'b1;
        if (count == 4'd0) begin
          commit    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      count         <= 4'd0;
      req_write     <= 1'b0;
      req_index     <= '0;
      req_data      <= '0;
      mem_read_data <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        // A write wins when both enables are sampled high.
        req_write <= mem_write_en;
        req_index <= mem_addr[INDEX_BITS-1:0];
        req_data  <= mem_write_data;
        count     <= COUNT_INIT;
      end else if (state == BUSY && count != 4'd0) begin
        count <= count - 4'd1;
      end
      if (commit && !req_write)
        mem_read_data <= lines[req_index];
    end
  end

  // NOTE: the line array has no reset; contents must survive a reset pulse.
  always_ff @(posedge clock) begin
    if (commit && req_write)
      lines[req_index] <= req_data;
  end

endmodule

// File: tb/tb_line_memory_responder.sv
// Randomized bench for line_memory_responder, LATENCY=4 and LATENCY=1 builds,
// checked against an array-based reference of the line store.
module tb_line_memory_responder;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         rd_en = 1'b0, wr_en = 1'b0;
  logic [29:0]  addr  = '0;
  logic [127:0] wdata = '0;
  int           sel   = 0;

  logic         rd4, wr4, rd1, wr1, busy4, busy1;
  logic [127:0] rdata4, rdata1;

  assign rd4 = rd_en & (sel == 0);
  assign wr4 = wr_en & (sel == 0);
  assign rd1 = rd_en & (sel == 1);
  assign wr1 = wr_en & (sel == 1);

  always #5 clock = ~clock;

  line_memory_responder #(.LATENCY(4), .INDEX_BITS(8)) dut4 (
    .clock(clock), .reset(reset), .mem_read_en(rd4), .mem_write_en(wr4),
    .mem_addr(addr), .mem_write_data(wdata), .mem_read_data(rdata4),
    .mem_busywait(busy4));

  line_memory_responder #(.LATENCY(1), .INDEX_BITS(8)) dut1 (
    .clock(clock), .reset(reset), .mem_read_en(rd1), .mem_write_en(wr1),
    .mem_addr(addr), .mem_write_data(wdata), .mem_read_data(rdata1),
    .mem_busywait(busy1));

  // Reference: per-build line store and last value returned by a read.
  logic [127:0] mdl_mem   [2][256];
  bit           mdl_valid [2][256];
  logic [127:0] mdl_last  [2];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic        busy_mux();  return (sel == 0) ? busy4 : busy1;   endfunction
  function automatic logic [127:0] rdata_mux(); return (sel == 0) ? rdata4 : rdata1; endfunction

  function automatic logic [127:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One transaction: hold keeps inputs steady until busywait falls, otherwise the
  // inputs are dropped and scrambled after the first cycle; keep leaves the
  // enables high after DONE so the next call runs back-to-back.
  task automatic txn(input int s, input bit wr, input bit rd, input logic [29:0] a,
                     input logic [127:0] d, input bit hold, input bit keep);
    int lat;
    int cnt;
    int idx;
    lat = (s == 0) ? 4 : 1;
    idx = int'(a[7:0]);
    @(negedge clock);
    sel = s; wr_en = wr; rd_en = rd; addr = a; wdata = d;
    #1;
    cnt = 0;
    while (busy_mux() && cnt < 40) begin
      cnt++;
      @(negedge clock);
      if (!hold) begin
        wr_en = 1'b0; rd_en = 1'b0;
        addr = 30'($urandom()); wdata = rand_line();
      end
      #1;
    end
    check("busy_cycles", 128'(cnt), 128'(lat + 1));
    if (wr) begin
      mdl_mem[s][idx]   = d;
      mdl_valid[s][idx] = 1'b1;
      check("rdata_kept_on_write", rdata_mux(), mdl_last[s]);
    end else if (mdl_valid[s][idx]) begin
      mdl_last[s] = mdl_mem[s][idx];
      check("read_data", rdata_mux(), mdl_last[s]);
    end
    if (!keep) begin
      wr_en = 1'b0; rd_en = 1'b0;
    end
  endtask

  initial begin
    logic [29:0] ra;
    logic [127:0] saved3;
    for (int s = 0; s < 2; s++) begin
      mdl_last[s] = '0;
      for (int i = 0; i < 256; i++) mdl_valid[s][i] = 1'b0;
    end

    // Reset state, including the IDLE busywait rule while reset is low.
    #12;
    check("reset_busy4", 128'(busy4), 128'(0));
    check("reset_rdata4", rdata4, '0);
    check("reset_rdata1", rdata1, '0);
    rd_en = 1'b1; #1;
    check("reset_busy_follows_en", 128'(busy4), 128'(1));
    rd_en = 1'b0; #1;
    @(negedge clock); reset = 1'b1;

    // Write then read at index 1.
    txn(0, 1, 0, 30'd1, 128'd1, 1, 0);
    txn(0, 0, 1, 30'd1, '0, 1, 0);
    // Aliasing through the ignored upper address bits.
    txn(0, 1, 0, 30'h101, {16{8'hAA}}, 1, 0);
    txn(0, 0, 1, 30'h001, '0, 1, 0);
    // Both enables high: write wins.
    txn(0, 1, 1, 30'd5, {16{8'h55}}, 1, 0);
    txn(0, 0, 1, 30'd5, '0, 1, 0);
    // Single-cycle read request with scrambled inputs afterwards.
    txn(0, 1, 0, 30'd2, 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978, 0, 0);
    txn(0, 0, 1, 30'd2, '0, 0, 0);
    // Back-to-back: enables held through DONE start the next transaction.
    txn(0, 1, 0, 30'd7, 128'hDEAD_BEEF, 1, 1);
    txn(0, 0, 1, 30'd7, '0, 1, 0);

    // Reset two cycles into a write of index 3 discards it.
    saved3 = 128'hC0FF_EE00_1234;
    txn(0, 1, 0, 30'd3, saved3, 1, 0);
    @(negedge clock);
    sel = 0; wr_en = 1'b1; addr = 30'd3; wdata = '1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0; #1;
    check("midreset_busy_idle_rule", 128'(busy4), 128'(1));
    check("midreset_rdata", rdata4, '0);
    wr_en = 1'b0; #1;
    check("midreset_busy_low", 128'(busy4), 128'(0));
    mdl_last[0] = '0; mdl_last[1] = '0;
    @(negedge clock); reset = 1'b1;
    txn(0, 0, 1, 30'd3, '0, 1, 0);

    // Randomized traffic on both builds over a small set of seeded indices.
    for (int s = 0; s < 2; s++) begin
      for (int i = 8; i < 16; i++) txn(s, 1, 0, 30'(i), rand_line(), 1, 0);
      for (int n = 0; n < 30; n++) begin
        bit w, r, h, k;
        ra = 30'($urandom());
        ra[7:0] = 8'($urandom_range(8, 15));
        w = 1'($urandom_range(0, 1));
        r = w ? 1'($urandom_range(0, 1)) : 1'b1;
        h = 1'($urandom_range(0, 1));
        k = h && ($urandom_range(0, 3) == 0);
        txn(s, w, r, ra, rand_line(), h, k);
      end
      txn(s, 0, 1, 30'd9, '0, 1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/line_memory_responder.md
LINE_MEMORY_RESPONDER -- requirements
Module: line_memory_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 4, meaning edges from entering BUSY to commit; legal range 1..15.
REQ-002 The block SHALL have parameter INDEX_BITS, default 8, meaning line-array index width; the array holds 2^INDEX_BITS lines.
REQ-003 The block SHALL have port clock, input, 1 bit: the sole clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port mem_read_en, input, 1 bit: line read request from the cache.
REQ-006 The block SHALL have port mem_write_en, input, 1 bit: line write request from the cache.
REQ-007 The block SHALL have port mem_addr, input, 30 bits: line address; only mem_addr[INDEX_BITS-1:0] indexes the array, upper bits ignored.
REQ-008 The block SHALL have port mem_write_data, input, 128 bits: line to be written.
REQ-009 The block SHALL have port mem_read_data, output, 128 bits: registered line returned by the last read.
REQ-010 The block SHALL have port mem_busywait, output, 1 bit: high while a request is pending and not yet complete.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-012 In IDLE, mem_busywait SHALL equal (mem_read_en | mem_write_en) combinationally; in BUSY it SHALL be 1; in DONE it SHALL be 0.
REQ-013 At a rising edge in IDLE with either enable high, the block SHALL latch op, index and write data, load a 4-bit counter with LATENCY-1, and go to BUSY.
REQ-014 If both enables are high when sampled, the block SHALL perform a write; the read is dropped.
REQ-015 At each rising edge in BUSY with counter nonzero, the counter SHALL decrement.
REQ-016 At the rising edge in BUSY with counter zero, the block SHALL commit: a write stores the latched line to the array; a read loads mem_read_data from the array; then go to DONE.
REQ-017 In DONE, the next rising edge SHALL return to IDLE unconditionally.
REQ-018 mem_busywait SHALL be high for exactly LATENCY+1 consecutive cycles per transaction, then low for the DONE cycle.
REQ-019 Requests SHALL be latched once; changes to or deassertion of enables, mem_addr or mem_write_data during BUSY or DONE SHALL have no effect on the transaction in flight.
REQ-020 Enables still high in the cycle after DONE SHALL start a new transaction from IDLE; back-to-back transactions are therefore separated by exactly one non-busy cycle.
REQ-021 mem_read_data SHALL change only at a read commit; writes, including a write to the same index, SHALL NOT alter it.
REQ-022 A read of an index in the same transaction order after a write to that index SHALL return the written line.

Reset
REQ-023 On reset low, the block SHALL immediately enter IDLE, clear the counter and latched request, and drive mem_read_data to 0.
REQ-024 The line array SHALL NOT be cleared by reset; contents written before reset SHALL be preserved.
REQ-025 A transaction interrupted by reset before its commit edge SHALL be discarded with no array update.
REQ-026 While reset is low, mem_busywait SHALL follow the IDLE rule of REQ-012.

Verification
REQ-027 Write then read, LATENCY=4: write mem_addr=1, data=0x...0001 held until busywait low -> busywait high 5 cycles; read addr 1 -> mem_read_data=0x0000...0001 in DONE cycle.
REQ-028 Aliasing: write addr 0x101 data=0xAA..AA, read addr 0x001 -> returns 0xAA..AA, since INDEX_BITS=8.
REQ-029 Simultaneous enables: both high with addr 5, data 0x55..55 -> write performed; subsequent read addr 5 returns 0x55..55; mem_read_data unchanged in between.
REQ-030 Early drop: enable read addr 2 for one cycle only -> busywait still completes 5-cycle pattern, mem_read_data updated with line 2.
REQ-031 Reset mid-write: write addr 3 data 0xFF..FF, assert reset 2 cycles in -> busywait follows IDLE rule, mem_read_data=0; later read addr 3 returns its prior value, not 0xFF..FF.
REQ-032 LATENCY=1 build: any request -> busywait high exactly 2 cycles, low 1 cycle, correct data.
